tt_um_popcount_enum: RTL

- Inverse of the 4-input one-hot population-count block: takes a requested weight k (0..4, one-hot coded the same way) and enumerates every 4-bit pattern with exactly k ones.
- Patterns are emitted one per handshake, in ascending numeric order, over a valid/ready interface.
- Drives the bench side of the popcount block: each emitted pattern, fed back into that block, must reproduce the requested one-hot weight.
- Top-level TinyTapeout user module.

---
 rtl/tt_um_popcount_enum_if.sv | 20 ++
 rtl/tt_um_popcount_enum.sv | 100 ++++++++++
 2 files changed

// File: rtl/tt_um_popcount_enum_if.sv
// TinyTapeout user-module pin bundle for the popcount enumerator.
// Handshake: a pattern moves when uo_out[4] (valid) and ui_in[6] (ready) are both high at a rising clk edge; valid, pattern and last hold until then.
interface tt_um_popcount_enum_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/tt_um_popcount_enum.sv
// Enumerates all 4-bit patterns with a requested one-hot weight k, one per
// valid/ready handshake, in ascending numeric order.
module tt_um_popcount_enum (
  input logic                  clk,
  input logic                  rst_n,
  tt_um_popcount_enum_if.slave bus
);
  typedef enum logic {IDLE, EMIT} state_t;

  state_t     state, state_nx;
  logic [3:0] pattern, pattern_nx;
  logic [3:0] count, count_nx;
  logic       err, err_nx;

  logic [4:0] req;
  logic       start, ready, valid, last, handshake;
  logic       unused_ok;

  assign req       = bus.ui_in[4:0];
  assign start     = bus.ui_in[5];
  assign ready     = bus.ui_in[6];
  assign unused_ok = &{1'b0, bus.ui_in[7], bus.uio_in};

  // Smallest value above p with the same popcount; p itself if none exists.
  function automatic logic [3:0] next_same_weight(input logic [3:0] p);
    logic [3:0] r;
    logic [3:0] c;
    r = p;
    for (int i = 15; i >= 0; i--) begin
      c = i[3:0];
      if (c > p && $countones(c) == $countones(p)) r = c;
    end
    return r;
  endfunction

  function automatic logic [3:0] first_pattern(input logic [4:0] onehot);
    logic [3:0] r;
    r = 4'b0000;
    case (onehot)
      5'b00010: r = 4'b0001;
      5'b00100: r = 4'b0011;
      5'b01000: r = 4'b0111;
      5'b10000: r = 4'b1111;
      default:  r = 4'b0000;
    endcase
    return r;
  endfunction

  // The largest pattern of a weight has no larger sibling.
  assign valid     = (state == EMIT);
  assign last      = valid && (next_same_weight(pattern) == pattern);
  assign handshake = valid && ready;

  always_comb begin
    state_nx   = state;
    pattern_nx = pattern;
    count_nx   = count;
    err_nx     = err;
    case (state)
      IDLE: begin
        if (start) begin
          if ($onehot(req)) begin
            pattern_nx = first_pattern(req);
            count_nx   = 4'd0;
            err_nx     = 1'b0;
            state_nx   = EMIT;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      EMIT: begin
        if (handshake) begin
          count_nx = count + 4'd1;
          if (last) state_nx = IDLE;
          else      pattern_nx = next_same_weight(pattern);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pattern <= 4'd0;
      count   <= 4'd0;
      err     <= 1'b0;
    end else if (bus.ena) begin
      state   <= state_nx;
      pattern <= pattern_nx;
      count   <= count_nx;
      err     <= err_nx;
    end
  end

  assign bus.uo_out  = {err, valid, last, valid, pattern};
  assign bus.uio_out = {4'b0000, count};
  assign bus.uio_oe  = 8'h0F;
endmodule
